// File: rtl/spi_controller.sv
// spi_controller: mode-0 write-only SPI initiator sending {1'b1, addr, wdata} MSB first.
// SCLK, nCS and COPI are registered from next-state values, so each output follows state exactly.
module spi_controller #(
  parameter int CLK_DIV  = 4,
  parameter int CS_SETUP = 4,
  parameter int CS_HOLD  = 4,
  parameter int CS_GAP   = 8
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic [6:0] addr,
  input  logic [7:0] wdata,
  output logic       ready,
  output logic       busy,
  output logic       done,
  output logic       SCLK,
  output logic       nCS,
  output logic       COPI
);
  typedef enum logic [2:0] {IDLE, SETUP, SHIFT, HOLD, GAP} state_t;
  localparam logic [7:0] SETUP_END = 8'(CS_SETUP - 1);
  localparam logic [7:0] DIV_END   = 8'(CLK_DIV - 1);
  localparam logic [7:0] HOLD_END  = 8'(CS_HOLD - 1);
  localparam logic [7:0] GAP_END   = 8'(CS_GAP - 1);
  state_t      state_q, state_d;
  logic [7:0]  cnt_q, cnt_d;
  logic [3:0]  idx_q, idx_d;
  logic        hi_q, hi_d;
  logic [15:0] frame_q, frame_d;
  logic        sclk_q, sclk_d, ncs_q, ncs_d, copi_q, copi_d, busy_q, busy_d, done_q, done_d;
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q + 8'd1;
    idx_d   = idx_q;
    hi_d    = hi_q;
    frame_d = frame_q;
    done_d  = 1'b0;
    case (state_q)
      IDLE: begin
        cnt_d = 8'd0;
        idx_d = 4'd15;
        if (start) begin
          state_d = SETUP;
          frame_d = {1'b1, addr, wdata};
        end
      end
      SETUP: if (cnt_q == SETUP_END) begin
        state_d = SHIFT;
        cnt_d   = 8'd0;
        hi_d    = 1'b0;
      end
      // index only moves at the end of a high phase, so COPI changes exactly when SCLK falls
      SHIFT: if (cnt_q == DIV_END) begin
        cnt_d = 8'd0;
        hi_d  = !hi_q;
        if (hi_q) begin
          if (idx_q == 4'd0) state_d = HOLD;
          else idx_d = idx_q - 4'd1;
        end
      end
      HOLD: if (cnt_q == HOLD_END) begin
        state_d = GAP;
        cnt_d   = 8'd0;
      end
      GAP: if (cnt_q == GAP_END) begin
        state_d = IDLE;
        cnt_d   = 8'd0;
        done_d  = 1'b1;
      end
      default: state_d = IDLE;
    endcase
    ncs_d  = !(state_d == SETUP || state_d == SHIFT || state_d == HOLD);
    sclk_d = (state_d == SHIFT) && hi_d;
    copi_d = (state_d == IDLE || state_d == GAP) ? 1'b0 : frame_d[idx_d];
    busy_d = state_d != IDLE;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= 8'd0;
      idx_q   <= 4'd0;
      hi_q    <= 1'b0;
      frame_q <= 16'd0;
      sclk_q  <= 1'b0;
      ncs_q   <= 1'b1;
      copi_q  <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      hi_q    <= hi_d;
      frame_q <= frame_d;
      sclk_q  <= sclk_d;
      ncs_q   <= ncs_d;
      copi_q  <= copi_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end
  assign ready = state_q == IDLE;
  assign busy  = busy_q;
  assign done  = done_q;
  assign SCLK  = sclk_q;
  assign nCS   = ncs_q;
  assign COPI  = copi_q;
endmodule

// File: tb/tb_spi_controller.sv
// tb_spi_controller: pin-level monitor decodes frames and timing from nCS/SCLK/COPI;
// expectations come from the frame format and the parameter timing formulas.
module tb_spi_controller;
  logic clk = 0, rst_n = 0, start0 = 0, start1 = 0, sel = 0;
  logic [6:0] addr = 0;
  logic [7:0] wdata = 0;
  logic rdy0, bsy0, dn0, sc0, cs0, co0, rdy1, bsy1, dn1, sc1, cs1, co1;
  int vec = 0, errs = 0;

  always #5 clk = ~clk;

  spi_controller dut (.clk(clk), .rst_n(rst_n), .start(start0), .addr(addr), .wdata(wdata),
    .ready(rdy0), .busy(bsy0), .done(dn0), .SCLK(sc0), .nCS(cs0), .COPI(co0));
  spi_controller #(.CLK_DIV(1), .CS_SETUP(1), .CS_HOLD(1), .CS_GAP(1)) dut1 (.clk(clk),
    .rst_n(rst_n), .start(start1), .addr(addr), .wdata(wdata), .ready(rdy1), .busy(bsy1),
    .done(dn1), .SCLK(sc1), .nCS(cs1), .COPI(co1));

  logic m_sc, m_cs, m_co, m_rdy, m_dn, m_bsy;
  assign m_sc  = sel ? sc1 : sc0;
  assign m_cs  = sel ? cs1 : cs0;
  assign m_co  = sel ? co1 : co0;
  assign m_rdy = sel ? rdy1 : rdy0;
  assign m_dn  = sel ? dn1 : dn0;
  assign m_bsy = sel ? bsy1 : bsy0;

  logic p_sc = 0, p_cs = 1;
  logic [15:0] sh = 0;
  int rises = 0, low_cnt = 0, high_cnt = 0, first_rise = 0, tog = 0;
  int done_cnt = 0, busy_cnt = 0, done_hi = 0, idle_edges = 0;
  logic [15:0] fq[$];
  int rq[$], lq[$], gq[$], frq[$], tq[$];

  always @(negedge clk) begin
    if (!m_cs) low_cnt = p_cs ? 1 : low_cnt + 1;
    if (!m_cs && p_cs) begin
      gq.push_back(high_cnt);
      rises = 0;
      tog = 0;
      sh = 0;
    end
    if (!m_cs && m_sc != p_sc) tog++;
    if (!m_cs && m_sc && !p_sc) begin
      sh = {sh[14:0], m_co};
      rises++;
      if (rises == 1) first_rise = low_cnt;
    end
    if (m_cs && m_sc) idle_edges++;
    if (m_cs && !p_cs) begin
      fq.push_back(sh);
      rq.push_back(rises);
      lq.push_back(low_cnt);
      frq.push_back(first_rise);
      tq.push_back(tog);
    end
    if (m_cs) high_cnt = p_cs ? high_cnt + 1 : 1;
    if (m_dn) begin
      done_cnt++;
      done_hi = high_cnt;
    end
    if (m_bsy) busy_cnt++;
    p_sc = m_sc;
    p_cs = m_cs;
  end

  function automatic logic [15:0] exp_frame(input logic [6:0] a, input logic [7:0] d);
    return {1'b1, a, d};
  endfunction

  task automatic clear();
    fq.delete(); rq.delete(); lq.delete(); gq.delete(); frq.delete(); tq.delete();
    done_cnt = 0; busy_cnt = 0; idle_edges = 0;
  endtask

  task automatic send(input logic [6:0] a, input logic [7:0] d);
    for (int i = 0; i < 1000 && !m_rdy; i++) @(negedge clk);
    #1;
    vec++;
    if (!m_rdy) begin errs++; $display("FAIL ready_wait got ready=%b want 1", m_rdy); end
    addr = a; wdata = d;
    if (sel) start1 = 1; else start0 = 1;
    @(negedge clk);
    start0 = 0; start1 = 0;
  endtask

  task automatic wait_frames(input int n, output bit ok);
    for (int i = 0; i < 3000 && fq.size() < n; i++) begin @(negedge clk); #1; end
    ok = fq.size() >= n;
  endtask

  task automatic wait_done(input int n, output bit ok);
    for (int i = 0; i < 3000 && done_cnt < n; i++) begin @(negedge clk); #1; end
    ok = done_cnt >= n;
  endtask

  task automatic test_reset();
    repeat (3) @(negedge clk);
    vec++;
    if ({cs0, sc0, co0, bsy0, dn0, rdy0} !== 6'b100001) begin
      errs++; $display("FAIL reset_state got cs/sc/co/busy/done/rdy=%b want 100001", {cs0, sc0, co0, bsy0, dn0, rdy0});
    end
    rst_n = 1;
    @(negedge clk);
  endtask

  task automatic test_basic();
    bit ok;
    clear();
    send(7'h00, 8'hA5);
    wait_done(1, ok);
    repeat (5) @(negedge clk);
    #1;
    vec++; if (!ok || fq.size() != 1) begin errs++; $display("FAIL basic_frames got %0d want 1", fq.size()); end
    vec++; if (fq[0] !== exp_frame(7'h00, 8'hA5)) begin errs++; $display("FAIL basic_bits got %h want %h", fq[0], exp_frame(7'h00, 8'hA5)); end
    vec++; if (rq[0] != 16) begin errs++; $display("FAIL basic_rises got %0d want 16", rq[0]); end
    vec++; if (lq[0] != 4 + 32 * 4 + 4) begin errs++; $display("FAIL basic_ncs_low got %0d want 136", lq[0]); end
    vec++; if (frq[0] != 4 + 4 + 1) begin errs++; $display("FAIL basic_first_rise got %0d want 9", frq[0]); end
    vec++; if (tq[0] != 32) begin errs++; $display("FAIL basic_toggles got %0d want 32", tq[0]); end
    vec++; if (done_cnt != 1) begin errs++; $display("FAIL basic_done_count got %0d want 1", done_cnt); end
    vec++; if (done_hi != 8 + 1) begin errs++; $display("FAIL basic_done_timing got %0d want 9", done_hi); end
    vec++; if (busy_cnt != 136 + 8) begin errs++; $display("FAIL basic_busy_len got %0d want 144", busy_cnt); end
    vec++; if (idle_edges != 0) begin errs++; $display("FAIL basic_idle_sclk got %0d want 0", idle_edges); end
  endtask

  task automatic test_back_to_back();
    bit ok;
    int i;
    clear();
    for (i = 0; i < 1000 && !rdy0; i++) @(negedge clk);
    addr = 7'h04; wdata = 8'h80; start0 = 1;
    @(negedge clk);
    addr = 7'h01; wdata = 8'hFF;
    for (i = 0; i < 3000 && gq.size() < 2; i++) begin @(negedge clk); #1; end
    start0 = 0;
    wait_frames(2, ok);
    wait_done(2, ok);
    repeat (20) @(negedge clk);
    #1;
    vec++; if (!ok || fq.size() != 2) begin errs++; $display("FAIL b2b_frames got %0d want 2", fq.size()); end
    vec++; if (fq[0] !== exp_frame(7'h04, 8'h80)) begin errs++; $display("FAIL b2b_first got %h want %h", fq[0], exp_frame(7'h04, 8'h80)); end
    vec++; if (fq[1] !== exp_frame(7'h01, 8'hFF)) begin errs++; $display("FAIL b2b_second got %h want %h", fq[1], exp_frame(7'h01, 8'hFF)); end
    vec++; if (gq[1] != 9) begin errs++; $display("FAIL b2b_gap got %0d want 9", gq[1]); end
    vec++; if (lq[1] != 136) begin errs++; $display("FAIL b2b_low2 got %0d want 136", lq[1]); end
  endtask

  task automatic test_ignore_busy();
    bit ok;
    clear();
    send(7'h11, 8'h22);
    for (int i = 0; i < 2000 && rises < 9; i++) begin @(negedge clk); #1; end
    addr = 7'h55; wdata = 8'h66; start0 = 1;
    @(negedge clk);
    start0 = 0;
    wait_done(1, ok);
    repeat (300) @(negedge clk);
    #1;
    vec++; if (!ok || fq.size() != 1) begin errs++; $display("FAIL ignore_frames got %0d want 1", fq.size()); end
    vec++; if (fq[0] !== exp_frame(7'h11, 8'h22)) begin errs++; $display("FAIL ignore_bits got %h want %h", fq[0], exp_frame(7'h11, 8'h22)); end
    vec++; if (done_cnt != 1) begin errs++; $display("FAIL ignore_done got %0d want 1", done_cnt); end
  endtask

  task automatic test_reset_mid();
    bit ok;
    logic [6:0] a;
    logic [7:0] d;
    clear();
    send(7'($urandom), 8'($urandom));
    for (int i = 0; i < 2000 && !(rises == 7 && sc0); i++) begin @(negedge clk); #1; end
    #2 rst_n = 0;
    #1;
    vec++;
    if ({cs0, sc0, co0, bsy0} !== 4'b1000) begin
      errs++; $display("FAIL midreset_outputs got cs/sc/co/busy=%b want 1000", {cs0, sc0, co0, bsy0});
    end
    @(negedge clk);
    rst_n = 1;
    #1;
    vec++; if (rdy0 !== 1'b1) begin errs++; $display("FAIL midreset_ready got %b want 1", rdy0); end
    @(negedge clk);
    clear();
    a = 7'($urandom); d = 8'($urandom);
    send(a, d);
    wait_frames(1, ok);
    vec++; if (!ok || fq[0] !== exp_frame(a, d)) begin errs++; $display("FAIL midreset_after got %h want %h", fq[0], exp_frame(a, d)); end
    vec++; if (rq[0] != 16) begin errs++; $display("FAIL midreset_rises got %0d want 16", rq[0]); end
    wait_done(1, ok);
  endtask

  task automatic test_fast();
    bit ok;
    @(negedge clk);
    sel = 1;
    @(negedge clk);
    clear();
    send(7'h7F, 8'h00);
    wait_frames(1, ok);
    wait_done(1, ok);
    repeat (3) @(negedge clk);
    #1;
    vec++; if (!ok || fq[0] !== 16'hFF00) begin errs++; $display("FAIL fast_bits got %h want ff00", fq[0]); end
    vec++; if (lq[0] != 34) begin errs++; $display("FAIL fast_ncs_low got %0d want 34", lq[0]); end
    vec++; if (tq[0] != 32) begin errs++; $display("FAIL fast_toggles got %0d want 32", tq[0]); end
    vec++; if (frq[0] != 3) begin errs++; $display("FAIL fast_first_rise got %0d want 3", frq[0]); end
    vec++; if (busy_cnt != 35) begin errs++; $display("FAIL fast_busy got %0d want 35", busy_cnt); end
    sel = 0;
    @(negedge clk);
  endtask

  task automatic test_random();
    bit ok;
    logic [15:0] expq[$];
    logic [6:0] a;
    logic [7:0] d;
    clear();
    for (int n = 0; n < 6; n++) begin
      a = 7'($urandom); d = 8'($urandom_range(0, 255));
      expq.push_back(exp_frame(a, d));
      send(a, d);
      wait_done(n + 1, ok);
    end
    for (int n = 0; n < 6; n++) begin
      vec++;
      if (n >= fq.size() || fq[n] !== expq[n] || lq[n] != 136) begin
        errs++; $display("FAIL random_frame%0d got %h len %0d want %h len 136", n, fq[n], lq[n], expq[n]);
      end
    end
  endtask

  task automatic test_loopback();
    bit ok;
    clear();
    send(7'h02, 8'h3C);
    wait_frames(1, ok);
    wait_done(1, ok);
    vec++; if (!ok || fq[0][14:8] !== 7'h02 || fq[0][15] !== 1'b1) begin errs++; $display("FAIL loop_addr got %h want 02 write", fq[0][14:8]); end
    vec++; if (fq[0][7:0] !== 8'h3C) begin errs++; $display("FAIL loop_data got %h want 3c", fq[0][7:0]); end
    vec++; if (idle_edges != 0) begin errs++; $display("FAIL loop_idle_sclk got %0d want 0", idle_edges); end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_back_to_back();
    test_ignore_busy();
    test_reset_mid();
    test_fast();
    test_random();
    test_loopback();
    $display("== %0d vectors applied, %0d miscompares ==", vec, errs);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout reached");
    $fatal(1, "timeout");
  end
endmodule
